// File: rtl/strawman_pkg.sv
// Shared definitions for the strawman link receive path: command and error
// encodings, header field positions, decoder states and burst sizing.
package strawman_pkg;

    localparam logic [2:0] CMD_RD_REQ  = 3'b000;
    localparam logic [2:0] CMD_WR_REQ  = 3'b001;
    localparam logic [2:0] CMD_RD_RESP = 3'b010;

    localparam int HDR_EXT_BIT     = 0;
    localparam int HDR_VALID_BIT   = 1;
    localparam int HDR_CMD_LSB     = 2;
    localparam int HDR_LEN_LSB     = 5;
    localparam int HDR_F1_LSB      = 8;
    localparam int HDR_F2_LSB      = 14;
    localparam int HDR_PAYLOAD_LSB = 8;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD = 2'b01;
    localparam logic [1:0] ERR_BAD_LEN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EXT_ADDR = 2'b01,
        ST_BODY     = 2'b10
    } state_e;

    localparam int BEATS_W = 16;

    // A length code selects a burst of 2^code data words.
    function automatic logic [BEATS_W-1:0] len_to_beats(input logic [2:0] len_code);
        return 16'd1 << len_code;
    endfunction

endpackage

// File: rtl/strawman_rx_out_stage.sv
// Single output register stage for decoded headers and data words; holds its
// contents while valid and the consumer is not ready.
module strawman_rx_out_stage
    import strawman_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 hdr_load,
    input  logic [2:0]           hdr_cmd,
    input  logic [2:0]           hdr_len,
    input  logic                 hdr_ext,
    input  logic [WORD_SIZE-1:0] hdr_addr,
    input  logic [5:0]           hdr_f1,
    input  logic [5:0]           hdr_f2,
    input  logic                 data_load,
    input  logic [WORD_SIZE-1:0] data_word,
    input  logic                 data_last,
    input  logic                 out_ready,
    output logic                 stage_ready,
    output logic                 o_hdr_valid,
    output logic [2:0]           o_cmd,
    output logic [2:0]           o_len,
    output logic                 o_ext,
    output logic [WORD_SIZE-1:0] o_addr,
    output logic [5:0]           o_feature1,
    output logic [5:0]           o_feature2,
    output logic                 o_data_valid,
    output logic [WORD_SIZE-1:0] o_data,
    output logic                 o_data_last
);

    assign stage_ready = !(o_hdr_valid || o_data_valid) || out_ready;

    // Output registers: a load replaces the record, a consume clears the valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hdr_valid  <= 1'b0;
            o_cmd        <= 3'b000;
            o_len        <= 3'b000;
            o_ext        <= 1'b0;
            o_addr       <= '0;
            o_feature1   <= 6'd0;
            o_feature2   <= 6'd0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_data_last  <= 1'b0;
        end else if (load) begin
            o_hdr_valid  <= hdr_load;
            o_data_valid <= data_load;
            if (hdr_load) begin
                o_cmd      <= hdr_cmd;
                o_len      <= hdr_len;
                o_ext      <= hdr_ext;
                o_addr     <= hdr_addr;
                o_feature1 <= hdr_f1;
                o_feature2 <= hdr_f2;
            end
            if (data_load) begin
                o_data      <= data_word;
                o_data_last <= data_last;
            end
        end else if (out_ready) begin
            o_hdr_valid  <= 1'b0;
            o_data_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/strawman_rx_decoder.sv
// Second-generation strawman receive decoder: parses lightweight and extended
// headers from RX FIFO flits and streams header records and data words out.
module strawman_rx_decoder
    import strawman_pkg::*;
#(
    parameter int DATA_LINE_WIDTH = 40,
    parameter int WORD_SIZE       = 32,
    parameter int MAX_LEN_CODE    = 5,
    parameter int CNT_W           = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_LINE_WIDTH-1:0] i_flit,
    input  logic                       i_flit_valid,
    output logic                       o_flit_ready,
    output logic                       o_hdr_valid,
    output logic [2:0]                 o_cmd,
    output logic [2:0]                 o_len,
    output logic                       o_ext,
    output logic [WORD_SIZE-1:0]       o_addr,
    output logic [5:0]                 o_feature1,
    output logic [5:0]                 o_feature2,
    output logic                       o_data_valid,
    output logic [WORD_SIZE-1:0]       o_data,
    output logic                       o_data_last,
    input  logic                       i_out_ready,
    output logic                       o_err,
    output logic [1:0]                 o_err_code,
    output logic                       o_busy
);

    localparam logic [2:0] MAX_LEN = 3'(MAX_LEN_CODE);

    state_e               state_r;
    logic [CNT_W-1:0]     beats_r;
    logic [2:0]           lat_cmd_r;
    logic [2:0]           lat_len_r;
    logic [5:0]           lat_f1_r;
    logic [5:0]           lat_f2_r;
    logic                 err_r;
    logic [1:0]           err_code_r;

    logic                 accept_s;
    logic                 stage_ready_s;
    logic                 hdr_vld_s;
    logic                 hdr_ext_s;
    logic [2:0]           hdr_cmd_s;
    logic [2:0]           hdr_len_s;
    logic [5:0]           hdr_f1_s;
    logic [5:0]           hdr_f2_s;
    logic [WORD_SIZE-1:0] payload_s;
    logic [WORD_SIZE-1:0] body_word_s;
    logic                 bad_cmd_s;
    logic                 bad_len_s;
    logic [CNT_W-1:0]     hdr_beats_s;
    logic [CNT_W-1:0]     lat_beats_s;

    logic                 ld_hdr_s;
    logic [2:0]           ld_cmd_s;
    logic [2:0]           ld_len_s;
    logic                 ld_ext_s;
    logic [WORD_SIZE-1:0] ld_addr_s;
    logic [5:0]           ld_f1_s;
    logic [5:0]           ld_f2_s;
    logic                 ld_data_s;
    logic [WORD_SIZE-1:0] ld_word_s;
    logic                 ld_last_s;

    assign o_flit_ready = stage_ready_s;
    assign accept_s     = i_flit_valid && stage_ready_s;
    assign hdr_vld_s    = i_flit[HDR_VALID_BIT];
    assign hdr_ext_s    = i_flit[HDR_EXT_BIT];
    assign hdr_cmd_s    = i_flit[HDR_CMD_LSB +: 3];
    assign hdr_len_s    = i_flit[HDR_LEN_LSB +: 3];
    assign hdr_f1_s     = i_flit[HDR_F1_LSB +: 6];
    assign hdr_f2_s     = i_flit[HDR_F2_LSB +: 6];
    assign payload_s    = i_flit[HDR_PAYLOAD_LSB +: WORD_SIZE];
    assign body_word_s  = i_flit[WORD_SIZE-1:0];
    assign bad_cmd_s    = hdr_cmd_s > CMD_RD_RESP;
    assign bad_len_s    = hdr_len_s > MAX_LEN;
    assign hdr_beats_s  = CNT_W'(len_to_beats(hdr_len_s));
    assign lat_beats_s  = CNT_W'(len_to_beats(lat_len_r));
    assign o_err        = err_r;
    assign o_err_code   = err_code_r;
    assign o_busy       = (state_r != ST_IDLE);

    // Decode what the accepted flit loads into the output stage.
    always_comb begin
        ld_hdr_s  = 1'b0;
        ld_cmd_s  = hdr_cmd_s;
        ld_len_s  = hdr_len_s;
        ld_ext_s  = hdr_ext_s;
        ld_addr_s = '0;
        ld_f1_s   = 6'd0;
        ld_f2_s   = 6'd0;
        ld_data_s = 1'b0;
        ld_word_s = body_word_s;
        ld_last_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && hdr_vld_s && !bad_cmd_s && !bad_len_s) begin
                    if (!hdr_ext_s) begin
                        ld_hdr_s = 1'b1;
                        if (hdr_cmd_s == CMD_RD_RESP) begin
                            ld_data_s = 1'b1;
                            ld_word_s = payload_s;
                            ld_last_s = (hdr_len_s == 3'd0);
                        end else begin
                            ld_addr_s = payload_s;
                        end
                    end else if (hdr_cmd_s == CMD_RD_RESP) begin
                        ld_hdr_s = 1'b1;
                        ld_f1_s  = hdr_f1_s;
                        ld_f2_s  = hdr_f2_s;
                    end else begin
                        ld_hdr_s = 1'b0;
                    end
                end else begin
                    ld_hdr_s = 1'b0;
                end
            end
            ST_EXT_ADDR: begin
                if (accept_s) begin
                    ld_hdr_s  = 1'b1;
                    ld_cmd_s  = lat_cmd_r;
                    ld_len_s  = lat_len_r;
                    ld_ext_s  = 1'b1;
                    ld_addr_s = body_word_s;
                    ld_f1_s   = lat_f1_r;
                    ld_f2_s   = lat_f2_r;
                end else begin
                    ld_hdr_s = 1'b0;
                end
            end
            ST_BODY: begin
                if (accept_s) begin
                    ld_data_s = 1'b1;
                    ld_last_s = (beats_r == CNT_W'(1));
                end else begin
                    ld_data_s = 1'b0;
                end
            end
            default: begin
                ld_hdr_s  = 1'b0;
                ld_data_s = 1'b0;
            end
        endcase
    end

    // Decoder FSM: state, remaining beats, latched extended fields, error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            beats_r    <= '0;
            lat_cmd_r  <= 3'b000;
            lat_len_r  <= 3'b000;
            lat_f1_r   <= 6'd0;
            lat_f2_r   <= 6'd0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
        end else begin
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!hdr_vld_s) begin
                            state_r <= ST_IDLE;
                        end else if (bad_cmd_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_BAD_CMD;
                        end else if (bad_len_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= ERR_BAD_LEN;
                        end else if (!hdr_ext_s) begin
                            if (hdr_cmd_s == CMD_WR_REQ) begin
                                beats_r <= hdr_beats_s;
                                state_r <= ST_BODY;
                            end else if (hdr_cmd_s == CMD_RD_RESP && hdr_len_s != 3'd0) begin
                                // Word 0 already travelled in the header payload.
                                beats_r <= hdr_beats_s - CNT_W'(1);
                                state_r <= ST_BODY;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            lat_cmd_r <= hdr_cmd_s;
                            lat_len_r <= hdr_len_s;
                            lat_f1_r  <= hdr_f1_s;
                            lat_f2_r  <= hdr_f2_s;
                            if (hdr_cmd_s == CMD_RD_RESP) begin
                                beats_r <= hdr_beats_s;
                                state_r <= ST_BODY;
                            end else begin
                                state_r <= ST_EXT_ADDR;
                            end
                        end
                    end
                    ST_EXT_ADDR: begin
                        if (lat_cmd_r == CMD_WR_REQ) begin
                            beats_r <= lat_beats_s;
                            state_r <= ST_BODY;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_BODY: begin
                        beats_r <= beats_r - CNT_W'(1);
                        if (beats_r == CNT_W'(1)) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    strawman_rx_out_stage #(
        .WORD_SIZE (WORD_SIZE)
    ) u_out_stage (
        .clk          (clk),
        .rst          (rst),
        .load         (accept_s),
        .hdr_load     (ld_hdr_s),
        .hdr_cmd      (ld_cmd_s),
        .hdr_len      (ld_len_s),
        .hdr_ext      (ld_ext_s),
        .hdr_addr     (ld_addr_s),
        .hdr_f1       (ld_f1_s),
        .hdr_f2       (ld_f2_s),
        .data_load    (ld_data_s),
        .data_word    (ld_word_s),
        .data_last    (ld_last_s),
        .out_ready    (i_out_ready),
        .stage_ready  (stage_ready_s),
        .o_hdr_valid  (o_hdr_valid),
        .o_cmd        (o_cmd),
        .o_len        (o_len),
        .o_ext        (o_ext),
        .o_addr       (o_addr),
        .o_feature1   (o_feature1),
        .o_feature2   (o_feature2),
        .o_data_valid (o_data_valid),
        .o_data       (o_data),
        .o_data_last  (o_data_last)
    );

endmodule

// File: tb/tb_strawman_rx_decoder.sv
// Bench for strawman_rx_decoder: directed scenarios plus a randomized flit
// stream checked against a stream-level reference decode.
module tb_strawman_rx_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] i_flit;
    logic        i_flit_valid;
    logic        o_flit_ready;
    logic        o_hdr_valid;
    logic [2:0]  o_cmd;
    logic [2:0]  o_len;
    logic        o_ext;
    logic [31:0] o_addr;
    logic [5:0]  o_feature1;
    logic [5:0]  o_feature2;
    logic        o_data_valid;
    logic [31:0] o_data;
    logic        o_data_last;
    logic        i_out_ready;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic        o_busy;

    strawman_rx_decoder dut (
        .clk(clk), .rst(rst), .i_flit(i_flit), .i_flit_valid(i_flit_valid),
        .o_flit_ready(o_flit_ready), .o_hdr_valid(o_hdr_valid), .o_cmd(o_cmd),
        .o_len(o_len), .o_ext(o_ext), .o_addr(o_addr), .o_feature1(o_feature1),
        .o_feature2(o_feature2), .o_data_valid(o_data_valid), .o_data(o_data),
        .o_data_last(o_data_last), .i_out_ready(i_out_ready), .o_err(o_err),
        .o_err_code(o_err_code), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hv;
        logic [2:0]  cmd;
        logic [2:0]  len;
        logic        ext;
        logic [31:0] addr;
        logic [5:0]  f1;
        logic [5:0]  f2;
        logic        dv;
        logic [31:0] data;
        logic        last;
    } rec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic        ready_seen;
    logic [39:0] stream[$];
    rec_t        exp_q[$];
    logic [1:0]  err_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic rec_t obs_rec();
        rec_t r;
        r.hv = o_hdr_valid; r.cmd = o_cmd; r.len = o_len; r.ext = o_ext;
        r.addr = o_addr; r.f1 = o_feature1; r.f2 = o_feature2;
        r.dv = o_data_valid; r.data = o_data; r.last = o_data_last;
        return r;
    endfunction

    // Fields of an invalid half carry no meaning, so they are zeroed before comparing.
    function automatic logic [127:0] masked(input rec_t r);
        rec_t m = r;
        if (!m.hv) begin m.cmd = '0; m.len = '0; m.ext = 1'b0; m.addr = '0; m.f1 = '0; m.f2 = '0; end
        if (!m.dv) begin m.data = '0; m.last = 1'b0; end
        return 128'(m);
    endfunction

    task automatic cyc(input logic [39:0] f, input logic v, input logic rdy);
        i_flit = f; i_flit_valid = v; i_out_ready = rdy;
        @(negedge clk);
        ready_seen = o_flit_ready;
        @(posedge clk);
        #1;
    endtask

    // Random packet generator: header plus the number of following flits it implies.
    task automatic gen_pkt();
        logic [39:0] h;
        int kind, nb, beats;
        logic [2:0] cmd, len;
        h = {8'($urandom), $urandom};
        kind = $urandom_range(0, 9);
        nb = 0;
        if (kind == 0) begin
            h[1] = 1'b0;
        end else if (kind == 1) begin
            h[1] = 1'b1; h[4:2] = 3'($urandom_range(3, 7));
        end else if (kind == 2) begin
            h[1] = 1'b1; h[4:2] = 3'($urandom_range(0, 2)); h[7:5] = 3'($urandom_range(6, 7));
        end else begin
            cmd = 3'($urandom_range(0, 2));
            len = 3'($urandom_range(0, 5));
            h[1] = 1'b1; h[4:2] = cmd; h[7:5] = len;
            beats = 1 << len;
            if (h[0]) nb = (cmd == 3'd2) ? beats : ((cmd == 3'd1) ? beats + 1 : 1);
            else nb = (cmd == 3'd2) ? beats - 1 : ((cmd == 3'd1) ? beats : 0);
        end
        stream.push_back(h);
        for (int k = 0; k < nb; k++) stream.push_back({8'($urandom), $urandom});
    endtask

    // Reference decode of the whole flit stream into expected records and errors.
    task automatic build_expect();
        int i, nd, beats;
        logic [39:0] h;
        logic [2:0] cmd, len;
        rec_t r;
        i = 0;
        while (i < stream.size()) begin
            h = stream[i]; i++;
            cmd = h[4:2]; len = h[7:5]; beats = 1 << len;
            nd = 0;
            if (!h[1]) continue;
            if (cmd > 3'd2) begin err_q.push_back(2'b01); continue; end
            if (len > 3'd5) begin err_q.push_back(2'b10); continue; end
            r = '0; r.hv = 1'b1; r.cmd = cmd; r.len = len; r.ext = h[0];
            if (!h[0] && cmd == 3'd2) begin
                r.dv = 1'b1; r.data = h[39:8]; r.last = (len == 3'd0);
                nd = beats - 1;
            end else if (!h[0]) begin
                r.addr = h[39:8];
                nd = (cmd == 3'd1) ? beats : 0;
            end else if (cmd == 3'd2) begin
                r.f1 = h[13:8]; r.f2 = h[19:14];
                nd = beats;
            end else begin
                r.f1 = h[13:8]; r.f2 = h[19:14]; r.addr = stream[i][31:0]; i++;
                nd = (cmd == 3'd1) ? beats : 0;
            end
            exp_q.push_back(r);
            for (int k = 0; k < nd; k++) begin
                r = '0; r.dv = 1'b1; r.data = stream[i][31:0]; r.last = (k == nd - 1);
                i++;
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic run_random();
        int idx, budget;
        logic v, rdy, stalled;
        rec_t o, prev;
        idx = 0; budget = 0; stalled = 1'b0; prev = '0;
        while ((idx < stream.size() || exp_q.size() > 0) && budget < 20000) begin
            budget++;
            v   = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            i_flit = v ? stream[idx] : {8'($urandom), $urandom};
            i_flit_valid = v; i_out_ready = rdy;
            @(negedge clk);
            o = obs_rec();
            if (stalled) chk("hold", masked(o), masked(prev));
            if ((o.hv || o.dv) && rdy) begin
                if (exp_q.size() > 0) chk("rand_out", masked(o), masked(exp_q.pop_front()));
                else chk("extra_out", masked(o), 128'd0);
            end
            if (o_err) begin
                if (err_q.size() > 0) chk("rand_err", 128'(o_err_code), 128'(err_q.pop_front()));
                else chk("extra_err", 128'(o_err), 128'd0);
            end
            stalled = (o.hv || o.dv) && !rdy;
            prev = o;
            if (v && o_flit_ready) idx++;
            @(posedge clk);
            #1;
        end
        chk("rand_budget", 128'(budget < 20000), 128'd1);
        chk("rand_exp_left", 128'(exp_q.size()), 128'd0);
        chk("rand_err_left", 128'(err_q.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b1; i_flit = '0; i_flit_valid = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", masked(obs_rec()) | 128'(obs_rec()), 128'd0);
        chk("rst_busy_err", {126'd0, o_busy, o_err}, 128'd0);
        rst = 1'b0;
        chk("rst_ready", 128'(o_flit_ready), 128'd1);

        // Lightweight read response with a single word.
        cyc(40'hDEADBEEF0A, 1'b1, 1'b1);
        chk("lwresp_hv_dv", {126'd0, o_hdr_valid, o_data_valid}, 128'd3);
        chk("lwresp_word", {95'd0, o_data_last, o_data}, {95'd0, 1'b1, 32'hDEADBEEF});
        chk("lwresp_cmd_busy", {124'd0, o_cmd, o_busy}, {124'd0, 3'b010, 1'b0});

        // Lightweight write, 2 beats, with a stall on the first data word.
        cyc(40'h1000004026, 1'b1, 1'b1);
        chk("lwwr_back2back", 128'(ready_seen), 128'd1);
        chk("lwwr_hdr", {88'd0, o_hdr_valid, o_cmd, o_len, o_ext, o_addr},
            {88'd0, 1'b1, 3'b001, 3'd1, 1'b0, 32'h10000040});
        chk("lwwr_hdr_nodata", 128'(o_data_valid), 128'd0);
        cyc(40'h00AAAA0001, 1'b1, 1'b1);
        chk("lwwr_d0", {94'd0, o_hdr_valid, o_data_valid, o_data_last, o_data},
            {94'd0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001});
        chk("lwwr_busy", 128'(o_busy), 128'd1);
        for (int s = 0; s < 3; s++) begin
            cyc(40'h00AAAA0002, 1'b1, 1'b0);
            chk("stall_ready", 128'(ready_seen), 128'd0);
            chk("stall_data", {95'd0, o_data_valid, o_data}, {95'd0, 1'b1, 32'hAAAA0001});
        end
        cyc(40'h00AAAA0002, 1'b1, 1'b1);
        chk("lwwr_d1", {95'd0, o_data_last, o_data}, {95'd0, 1'b1, 32'hAAAA0002});
        cyc(40'h0, 1'b0, 1'b1);
        chk("lwwr_done", {125'd0, o_hdr_valid, o_data_valid, o_busy}, 128'd0);

        // Extended read request: header, then address flit.
        cyc(40'h0000028503, 1'b1, 1'b1);
        chk("extrd_pending", {126'd0, o_hdr_valid, o_busy}, {126'd0, 1'b0, 1'b1});
        cyc(40'h0020000100, 1'b1, 1'b1);
        chk("extrd_hdr", {76'd0, o_hdr_valid, o_cmd, o_len, o_ext, o_feature1, o_feature2, o_addr},
            {76'd0, 1'b1, 3'b000, 3'd0, 1'b1, 6'h05, 6'h0A, 32'h20000100});
        chk("extrd_nodata_idle", {126'd0, o_data_valid, o_busy}, 128'd0);

        // Bad command, then bad length.
        cyc(40'h16, 1'b1, 1'b1);
        chk("badcmd", {124'd0, o_err, o_err_code, o_hdr_valid}, {124'd0, 1'b1, 2'b01, 1'b0});
        cyc(40'hC6, 1'b1, 1'b1);
        chk("badlen", {124'd0, o_err, o_err_code, o_hdr_valid}, {124'd0, 1'b1, 2'b10, 1'b0});
        chk("badlen_idle", 128'(o_busy), 128'd0);
        cyc(40'h0, 1'b0, 1'b1);
        chk("err_pulse", 128'(o_err), 128'd0);

        // Reset in the middle of a 4-beat write.
        cyc(40'h1000004046, 1'b1, 1'b1);
        cyc(40'h0011110001, 1'b1, 1'b1);
        rst = 1'b1;
        cyc(40'h0011110002, 1'b1, 1'b1);
        chk("midrst_outs", 128'(obs_rec()), 128'd0);
        chk("midrst_busy_err", {126'd0, o_busy, o_err}, 128'd0);
        rst = 1'b0;
        cyc(40'h123456780A, 1'b1, 1'b1);
        chk("midrst_fresh", {93'd0, o_hdr_valid, o_data_valid, o_data_last, o_cmd == 3'b010, o_data},
            {93'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678});
        cyc(40'h0, 1'b0, 1'b1);

        for (int p = 0; p < 60; p++) gen_pkt();
        build_expect();
        run_random();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/strawman_rx_decoder.md
Name: strawman_rx_decoder

Overview:
Parametrised second-generation receive decoder for the strawman link protocol. It consumes one flit per accepted handshake from the RX FIFO and decodes lightweight and extended headers for read request, write request and read response. It emits a header record and a stream of data words on a backpressured output port. Unlike the first-generation FSM, it has explicit valid/ready on both sides, a real reset, a parametrised burst limit, a last-beat marker and error reporting.

Parameters:
DATA_LINE_WIDTH, 40, flit width; must be >= WORD_SIZE+8
WORD_SIZE, 32, data/address word width
MAX_LEN_CODE, 5, largest legal length code; burst = 2^code words (4B..128B at default)
CNT_W, 6, beat counter width; must hold 2^MAX_LEN_CODE

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_flit  in  DATA_LINE_WIDTH  flit from RX FIFO
i_flit_valid  in  1  i_flit holds a flit
o_flit_ready  out  1  decoder accepts i_flit this cycle (FIFO read enable)
o_hdr_valid  out  1  header record valid
o_cmd  out  3  000 read req, 001 write req, 010 read resp
o_len  out  3  length code
o_ext  out  1  extended-mode packet
o_addr  out  WORD_SIZE  address (requests only)
o_feature1  out  6  extended feature 1
o_feature2  out  6  extended feature 2
o_data_valid  out  1  data word valid
o_data  out  WORD_SIZE  data word
o_data_last  out  1  final data word of the packet
i_out_ready  in  1  consumer takes all currently valid outputs
o_err  out  1  one-cycle error pulse
o_err_code  out  2  01 bad cmd, 10 bad length
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. On reset, the FSM goes to IDLE, counters clear, and every output valid, o_err and o_busy go to 0. All data/field outputs go to 0.
- Handshake:
  - A flit is accepted when i_flit_valid && o_flit_ready.
  - There is one output register stage. o_flit_ready = !(o_hdr_valid || o_data_valid) || i_out_ready.
  - Outputs appear the cycle after acceptance (latency 1).
  - Outputs hold stable while valid and !i_out_ready.
- Header fields: [0] ext, [1] valid, [4:2] cmd, [7:5] len, [13:8] f1, [19:14] f2, lightweight payload [8+WORD_SIZE-1:8]. Body flits carry data in [WORD_SIZE-1:0].
- States:
  - IDLE
    - An accepted flit with bit1=0 is dropped silently.
    - cmd>010: o_err=1, code 01, stay IDLE.
    - len>MAX_LEN_CODE: o_err=1, code 10, stay IDLE. Bad cmd takes priority over bad length.
    - Lightweight read req: header valid with addr; stay IDLE.
    - Lightweight write req: header valid with addr; beats=2^len; go to BODY.
    - Lightweight read resp: header plus data word 0 (payload field) valid together. o_data_last=1 if len=0 (stay IDLE); else beats=2^len-1, go to BODY.
    - Extended req (read or write): latch f1/f2/len/cmd; go to EXT_ADDR.
    - Extended read resp: header valid with f1/f2; beats=2^len; go to BODY.
  - EXT_ADDR
    - The next accepted flit's [WORD_SIZE-1:0] is the addr; emit the header.
    - Read: go to IDLE. Write: beats=2^len; go to BODY.
  - BODY
    - Each accepted flit emits one data word and decrements beats. Bit1 is not checked.
    - On beats=1: o_data_last=1, go to IDLE.
- Boundaries:
  - A new header may be accepted the cycle after the last body flit; no bubble is required.
  - No flit is accepted while the output is stalled.
  - rst mid-packet abandons the packet. Remaining body flits later arriving in IDLE are decoded as headers, per the IDLE rules.
- o_err is a single-cycle pulse, independent of i_out_ready.
- o_busy=1 in EXT_ADDR and BODY.

Decomposition:
- Package strawman_pkg: cmd encodings, header bit-position constants, error codes, state encoding, len-code-to-beats function.
- Sub-module strawman_rx_out_stage: output register with valid/ready hold. The FSM and counter stay in the top module.

Test Plan:
1. Lightweight write 8B: flit 0x1000004026, then 0x00AAAA0001 and 0x00AAAA0002. Expect a header with cmd=001, addr=0x10000040, len=1, ext=0, then data 0xAAAA0001 and 0xAAAA0002 with last only on the second, each 1 cycle after acceptance.
2. Extended read req: flit 0x0000028503, then 0x0020000100. Expect one header with cmd=000, ext=1, f1=0x05, f2=0x0A, len=0, addr=0x20000100, no data, o_busy=1 for exactly 1 cycle.
3. Lightweight read resp 4B: flit 0xDEADBEEF0A. Expect header and data 0xDEADBEEF in the same cycle with last=1; the next header is accepted on the following cycle.
4. Backpressure: during scenario 1, hold i_out_ready=0 for 3 cycles after the first data word. Expect o_flit_ready=0 and o_data stable at 0xAAAA0001 throughout, with no flit lost.
5. Errors: flit 0x16 gives o_err=1 with code 01. Flit 0xC6 (len 6) gives o_err=1 with code 10. o_hdr_valid stays 0 and the FSM stays in IDLE.
6. Reset mid-body: assert rst after 1 of 4 write beats. Expect all outputs 0 and IDLE next cycle, then a fresh header decoded correctly.
